sobel_window3x3: RTL and testbench

- Streaming 3x3 neighbourhood generator directly upstream of the deterministic Sobel core.
- Accepts one raster-order 8-bit pixel per handshake and keeps two previous image lines in line buffers.
- Presents a registered 3x3 window on z1..z9: z1..z3 top row, z4..z6 middle row, z7..z9 bottom row, left to right. These outputs connect straight to the Sobel core's z1..z9 inputs.
- Border windows are not generated (valid-only convolution), so a W x H frame yields (W-2)*(H-2) windows.

---
 rtl/sobel_pkg.sv | 15 +
 rtl/sobel_window3x3_if.sv | 28 ++
 rtl/sobel_line_buffer.sv | 30 +++
 rtl/sobel_window3x3.sv | 101 ++++++++++
 tb/tb_sobel_window3x3.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel front end: pixel type and the width of the
// downstream gradient sum.
package sobel_pkg;

    localparam int PIX_W     = 8;
    localparam int WIN_OUT_W = 12;

    typedef logic [PIX_W-1:0] pixel_t;

    // Zero-extends a pixel to the Sobel accumulator width.
    function automatic logic [WIN_OUT_W-1:0] pix_extend(input pixel_t p);
        return {{(WIN_OUT_W - PIX_W){1'b0}}, p};
    endfunction

endpackage

// File: rtl/sobel_window3x3_if.sv
// Pixel-in / window-out stream bundle between the raster source, the window
// generator and the Sobel core.
interface sobel_window3x3_if;
    import sobel_pkg::*;

    logic   in_valid;
    logic   in_ready;
    logic   in_sof;
    pixel_t in_pixel;

    logic   out_valid;
    logic   out_ready;
    logic   out_last;
    pixel_t z1, z2, z3, z4, z5, z6, z7, z8, z9;

    modport master (
        output in_valid, in_sof, in_pixel, out_ready,
        input  in_ready, out_valid, out_last,
        input  z1, z2, z3, z4, z5, z6, z7, z8, z9
    );

    modport slave (
        input  in_valid, in_sof, in_pixel, out_ready,
        output in_ready, out_valid, out_last,
        output z1, z2, z3, z4, z5, z6, z7, z8, z9
    );

endinterface

// File: rtl/sobel_line_buffer.sv
// Two-line history for the 3x3 window: one read-before-write per accepted pixel.
// Returns row r-2 (a) and row r-1 (b) at the current column.
module sobel_line_buffer #(
    parameter int IMG_W  = 64,
    parameter int PIX_W  = 8,
    parameter int ADDR_W = $clog2(IMG_W)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [PIX_W-1:0]  din,
    output logic [PIX_W-1:0]  a,
    output logic [PIX_W-1:0]  b
);

    // Contents are never reset; row/col gating keeps stale data out of valid windows.
    logic [PIX_W-1:0] lb0 [IMG_W];
    logic [PIX_W-1:0] lb1 [IMG_W];

    assign a = lb1[addr];
    assign b = lb0[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            lb1[addr] <= lb0[addr];
            lb0[addr] <= din;
        end
    end

endmodule

// File: rtl/sobel_window3x3.sv
// Streaming 3x3 neighbourhood generator feeding the Sobel core; emits only
// interior windows, registered, with a single output stage at full throughput.
module sobel_window3x3
    import sobel_pkg::*;
#(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64,
    parameter int PIX_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    sobel_window3x3_if.slave  bus
);

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] COL_FIRST_WIN = COL_W'(2);
    localparam logic [ROW_W-1:0] ROW_FIRST_WIN = ROW_W'(2);

    logic [COL_W-1:0] col, col_cur;
    logic [ROW_W-1:0] row, row_cur;
    logic             accept;
    logic             out_valid_q;
    logic             out_last_q;
    logic [PIX_W-1:0] lb_a, lb_b;
    pixel_t           z_q [1:9];

    assign bus.in_ready = !out_valid_q || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;

    // Start-of-frame forces the accepted pixel to (0,0) whatever the counters say.
    assign col_cur = bus.in_sof ? '0 : col;
    assign row_cur = bus.in_sof ? '0 : row;

    sobel_line_buffer #(
        .IMG_W  (IMG_W),
        .PIX_W  (PIX_W),
        .ADDR_W (COL_W)
    ) u_line_buffer (
        .clk  (clk),
        .we   (accept),
        .addr (col_cur),
        .din  (bus.in_pixel),
        .a    (lb_a),
        .b    (lb_b)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col_cur == COL_LAST) begin
                col <= '0;
                row <= (row_cur == ROW_LAST) ? '0 : row_cur + 1'b1;
            end else begin
                col <= col_cur + 1'b1;
                row <= row_cur;
            end
        end
    end

    // The window shifts on every accept, including c=0/1, so the previous
    // line's columns are flushed before the first valid window of a row.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            z_q         <= '{default: '0};
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else if (accept) begin
            z_q[1]      <= z_q[2];
            z_q[2]      <= z_q[3];
            z_q[3]      <= lb_a;
            z_q[4]      <= z_q[5];
            z_q[5]      <= z_q[6];
            z_q[6]      <= lb_b;
            z_q[7]      <= z_q[8];
            z_q[8]      <= z_q[9];
            z_q[9]      <= bus.in_pixel;
            out_valid_q <= (row_cur >= ROW_FIRST_WIN) && (col_cur >= COL_FIRST_WIN);
            out_last_q  <= (row_cur == ROW_LAST) && (col_cur == COL_LAST);
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.z1 = z_q[1];
    assign bus.z2 = z_q[2];
    assign bus.z3 = z_q[3];
    assign bus.z4 = z_q[4];
    assign bus.z5 = z_q[5];
    assign bus.z6 = z_q[6];
    assign bus.z7 = z_q[7];
    assign bus.z8 = z_q[8];
    assign bus.z9 = z_q[9];

endmodule

// File: tb/tb_sobel_window3x3.sv
// Self-checking bench for sobel_window3x3 on a 4x4 frame: a frame-array model
// pushes expected windows at accept time, popped when the DUT offers a window.
module tb_sobel_window3x3;

    localparam int W = 4;
    localparam int H = 4;
    localparam logic [71:0] FIRST_WIN = 72'h00_01_02_10_11_12_20_21_22;

    typedef struct packed {
        logic [71:0] win;
        logic        last;
    } exp_t;

    logic clk;
    logic rst_n;
    sobel_window3x3_if bus();

    sobel_window3x3 #(.IMG_W(W), .IMG_H(H), .PIX_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          vectors;
    int          miscompares;
    int          m_row;
    int          m_col;
    logic [7:0]  img [0:H-1][0:W-1];
    exp_t        q[$];
    logic [71:0] zcat;

    assign zcat = {bus.z1, bus.z2, bus.z3, bus.z4, bus.z5, bus.z6, bus.z7, bus.z8, bus.z9};

    task automatic model_accept(input logic [7:0] p, input logic sof);
        exp_t e;
        if (sof) begin
            m_row = 0;
            m_col = 0;
        end
        img[m_row][m_col] = p;
        if (m_row >= 2 && m_col >= 2) begin
            e.win  = {img[m_row-2][m_col-2], img[m_row-2][m_col-1], img[m_row-2][m_col],
                      img[m_row-1][m_col-2], img[m_row-1][m_col-1], img[m_row-1][m_col],
                      img[m_row][m_col-2],   img[m_row][m_col-1],   img[m_row][m_col]};
            e.last = (m_row == H-1) && (m_col == W-1);
            q.push_back(e);
        end
        if (m_col == W-1) begin
            m_col = 0;
            m_row = (m_row == H-1) ? 0 : m_row + 1;
        end else begin
            m_col++;
        end
    endtask

    function automatic logic [7:0] frame_pix();
        return {m_row[3:0], m_col[3:0]};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_sof = 1'b0;
        bus.in_pixel = 8'h00;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.out_last !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_flags: valid=%b last=%b, required 0 0", bus.out_valid, bus.out_last);
        end
        vectors++;
        if (zcat !== 72'h0) begin
            miscompares++;
            $display("FAIL reset_window: z=%h, required 0", zcat);
        end
        vectors++;
        if (bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_in_ready: got %b, required 1", bus.in_ready);
        end
        rst_n = 1'b1;
        m_row = 0;
        m_col = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_free_run();
        int acc = 0, wins = 0, cyc = 0;
        logic [7:0] last_z5 = 8'h00;
        logic last_flag = 1'b0;
        exp_t e;
        bus.out_ready = 1'b1;
        bus.in_sof = 1'b0;
        while ((acc < 16 || q.size() != 0) && cyc < 100) begin
            bus.in_valid = (acc < 16);
            bus.in_pixel = frame_pix();
            #1;
            if (bus.out_valid) begin
                if (wins == 0) begin
                    vectors++;
                    if (acc !== 11) begin
                        miscompares++;
                        $display("FAIL free_latency: first window after %0d accepts, required 11", acc);
                    end
                    vectors++;
                    if (zcat !== FIRST_WIN) begin
                        miscompares++;
                        $display("FAIL free_first_window: z=%h, required %h", zcat, FIRST_WIN);
                    end
                end
                wins++;
                last_z5 = bus.z5;
                last_flag = bus.out_last;
                vectors++;
                if (q.size() == 0) begin
                    miscompares++;
                    $display("FAIL free_unexpected: window z=%h with nothing expected", zcat);
                end else begin
                    e = q.pop_front();
                    if (zcat !== e.win || bus.out_last !== e.last) begin
                        miscompares++;
                        $display("FAIL free_window: z=%h last=%b, required z=%h last=%b", zcat, bus.out_last, e.win, e.last);
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                model_accept(bus.in_pixel, bus.in_sof);
                acc++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        vectors++;
        if (wins !== 4 || cyc >= 100) begin
            miscompares++;
            $display("FAIL free_count: %0d windows in %0d cycles, required 4", wins, cyc);
        end
        vectors++;
        if (last_z5 !== 8'h22 || last_flag !== 1'b1) begin
            miscompares++;
            $display("FAIL free_last: z5=%h last=%b, required 22 1", last_z5, last_flag);
        end
    endtask

    task automatic test_stall();
        int acc = 0, wins = 0, cyc = 0, stall_left = 0;
        bit stalled = 0;
        exp_t e;
        bus.in_sof = 1'b0;
        while ((acc < 16 || q.size() != 0) && cyc < 100) begin
            bus.out_ready = (stall_left == 0);
            bus.in_valid = (acc < 16);
            bus.in_pixel = frame_pix();
            #1;
            if (stall_left > 0) begin
                vectors++;
                if (bus.in_ready !== 1'b0) begin
                    miscompares++;
                    $display("FAIL stall_in_ready: got %b, required 0", bus.in_ready);
                end
                vectors++;
                if (q.size() == 0 || bus.out_valid !== 1'b1 || zcat !== q[0].win) begin
                    miscompares++;
                    $display("FAIL stall_hold: valid=%b z=%h, required held window (queue %0d)", bus.out_valid, zcat, q.size());
                end
                stall_left--;
            end
            if (bus.out_valid && bus.out_ready) begin
                wins++;
                vectors++;
                if (q.size() == 0) begin
                    miscompares++;
                    $display("FAIL stall_unexpected: window z=%h with nothing expected", zcat);
                end else begin
                    e = q.pop_front();
                    if (zcat !== e.win || bus.out_last !== e.last) begin
                        miscompares++;
                        $display("FAIL stall_window: z=%h last=%b, required z=%h last=%b", zcat, bus.out_last, e.win, e.last);
                    end
                end
                if (!stalled) begin
                    stalled = 1;
                    stall_left = 3;
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                model_accept(bus.in_pixel, bus.in_sof);
                acc++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        vectors++;
        if (wins !== 4 || cyc >= 100) begin
            miscompares++;
            $display("FAIL stall_count: %0d windows in %0d cycles, required 4", wins, cyc);
        end
        bus.out_ready = 1'b1;
    endtask

    task automatic test_gaps();
        int acc = 0, wins = 0, cyc = 0;
        exp_t e;
        bus.out_ready = 1'b1;
        bus.in_sof = 1'b0;
        while ((acc < 16 || q.size() != 0) && cyc < 300) begin
            bus.in_valid = (acc < 16) && ($urandom_range(0, 1) == 1);
            bus.in_pixel = bus.in_valid ? frame_pix() : 8'hEE;
            #1;
            if (bus.out_valid) begin
                wins++;
                vectors++;
                if (q.size() == 0) begin
                    miscompares++;
                    $display("FAIL gaps_unexpected: window z=%h with nothing expected", zcat);
                end else begin
                    e = q.pop_front();
                    if (zcat !== e.win || bus.out_last !== e.last) begin
                        miscompares++;
                        $display("FAIL gaps_window: z=%h last=%b, required z=%h last=%b", zcat, bus.out_last, e.win, e.last);
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                model_accept(bus.in_pixel, bus.in_sof);
                acc++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        vectors++;
        if (wins !== 4 || cyc >= 300) begin
            miscompares++;
            $display("FAIL gaps_count: %0d windows in %0d cycles, required 4", wins, cyc);
        end
    endtask

    task automatic test_back_to_back();
        int acc = 0, wins = 0, cyc = 0;
        exp_t e;
        bus.out_ready = 1'b1;
        bus.in_sof = 1'b0;
        while ((acc < 32 || q.size() != 0) && cyc < 150) begin
            bus.in_valid = (acc < 32);
            bus.in_pixel = frame_pix();
            #1;
            if (bus.out_valid) begin
                if (wins == 4) begin
                    vectors++;
                    if (acc !== 27) begin
                        miscompares++;
                        $display("FAIL b2b_frame2_start: first frame-2 window after %0d accepts, required 27", acc);
                    end
                end
                wins++;
                vectors++;
                if (q.size() == 0) begin
                    miscompares++;
                    $display("FAIL b2b_unexpected: window z=%h with nothing expected", zcat);
                end else begin
                    e = q.pop_front();
                    if (zcat !== e.win || bus.out_last !== e.last) begin
                        miscompares++;
                        $display("FAIL b2b_window: z=%h last=%b, required z=%h last=%b", zcat, bus.out_last, e.win, e.last);
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                model_accept(bus.in_pixel, bus.in_sof);
                acc++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        vectors++;
        if (wins !== 8 || cyc >= 150) begin
            miscompares++;
            $display("FAIL b2b_count: %0d windows in %0d cycles, required 8", wins, cyc);
        end
    endtask

    task automatic test_sof_restart();
        int acc = 0, wins = 0, cyc = 0;
        exp_t e;
        bus.out_ready = 1'b1;
        while ((acc < 22 || q.size() != 0) && cyc < 150) begin
            bus.in_valid = (acc < 22);
            bus.in_sof = (acc == 6);
            bus.in_pixel = (acc < 6) ? 8'hE0 | 8'(acc) : (acc == 6) ? 8'h00 : frame_pix();
            #1;
            if (bus.out_valid) begin
                if (wins == 0) begin
                    vectors++;
                    if (acc !== 17 || zcat !== FIRST_WIN) begin
                        miscompares++;
                        $display("FAIL sof_first: after %0d accepts z=%h, required 17 accepts z=%h", acc, zcat, FIRST_WIN);
                    end
                end
                wins++;
                vectors++;
                if (q.size() == 0) begin
                    miscompares++;
                    $display("FAIL sof_unexpected: window z=%h with nothing expected", zcat);
                end else begin
                    e = q.pop_front();
                    if (zcat !== e.win || bus.out_last !== e.last) begin
                        miscompares++;
                        $display("FAIL sof_window: z=%h last=%b, required z=%h last=%b", zcat, bus.out_last, e.win, e.last);
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                model_accept(bus.in_pixel, bus.in_sof);
                acc++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        bus.in_sof = 1'b0;
        vectors++;
        if (wins !== 4 || cyc >= 150) begin
            miscompares++;
            $display("FAIL sof_count: %0d windows in %0d cycles, required 4", wins, cyc);
        end
    endtask

    task automatic test_mid_reset();
        int acc = 0, wins = 0, cyc = 0;
        exp_t e;
        bus.out_ready = 1'b1;
        bus.in_sof = 1'b0;
        for (int i = 0; i < 9; i++) begin
            bus.in_valid = 1'b1;
            bus.in_pixel = 8'h40 + 8'(i);
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.out_last !== 1'b0 || zcat !== 72'h0) begin
            miscompares++;
            $display("FAIL midrst_clear: valid=%b last=%b z=%h, required 0 0 0", bus.out_valid, bus.out_last, zcat);
        end
        m_row = 0;
        m_col = 0;
        q.delete();
        while ((acc < 16 || q.size() != 0) && cyc < 100) begin
            bus.in_valid = (acc < 16);
            bus.in_pixel = frame_pix();
            #1;
            if (bus.out_valid) begin
                wins++;
                vectors++;
                if (q.size() == 0) begin
                    miscompares++;
                    $display("FAIL midrst_unexpected: window z=%h with nothing expected", zcat);
                end else begin
                    e = q.pop_front();
                    if (zcat !== e.win || bus.out_last !== e.last) begin
                        miscompares++;
                        $display("FAIL midrst_window: z=%h last=%b, required z=%h last=%b", zcat, bus.out_last, e.win, e.last);
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                model_accept(bus.in_pixel, bus.in_sof);
                acc++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        vectors++;
        if (wins !== 4 || cyc >= 100) begin
            miscompares++;
            $display("FAIL midrst_count: %0d windows in %0d cycles, required 4", wins, cyc);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_free_run();
        test_stall();
        test_gaps();
        test_back_to_back();
        test_sof_restart();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
